// File: rtl/mat_inv_pkg.sv
// Shared FSM state encoding and divider sizing for the 2x2 matrix inverter.
package mat_inv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DET   = 3'd1,
    S_DIV   = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Quotient bits per element: W+2F result bits plus one rounding bit.
  function automatic int unsigned div_cycles(input int unsigned w, input int unsigned f);
    return w + 2 * f + 1;
  endfunction

endpackage

// File: rtl/udiv_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, NW cycles after start.
module udiv_iter #(
  parameter int unsigned NW = 45,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  logic [NW-1:0] i_num,
  input  logic [DW-1:0] i_den,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_last_c,
  output logic [NW-1:0] o_quot
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [NW-1:0] r_num;
  logic [DW-1:0] r_den;
  logic [DW-1:0] r_rem;
  logic [NW-1:0] r_quot;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [DW:0]   w_trial;
  logic          w_ge;
  logic [DW-1:0] w_rem_nxt;

  // Shift in the next numerator bit and subtract when the divisor fits.
  always_comb begin
    w_trial   = {r_rem, r_num[NW-1]};
    w_ge      = (w_trial >= {1'b0, r_den});
    w_rem_nxt = w_ge ? DW'(w_trial - {1'b0, r_den}) : w_trial[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_num  <= i_num;
        r_den  <= i_den;
        r_rem  <= '0;
        r_quot <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_num  <= {r_num[NW-2:0], 1'b0};
        r_rem  <= w_rem_nxt;
        r_quot <= {r_quot[NW-2:0], w_ge};
        r_cnt  <= r_cnt + CW'(1);
        if (r_cnt == CW'(NW - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_quot   = r_quot;
  assign o_last_c = r_busy && (r_cnt == CW'(NW - 1));

endmodule

// File: rtl/mat2_inv_iter.sv
// Iterative 2x2 fixed-point matrix inverse: adjugate / det with one shared divider.
module mat2_inv_iter
  import mat_inv_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned F = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] a_inv,
  output logic signed [W-1:0] b_inv,
  output logic signed [W-1:0] c_inv,
  output logic signed [W-1:0] d_inv,
  output logic                singular,
  output logic                overflow
);

  localparam int unsigned NW  = div_cycles(W, F);
  localparam int unsigned NW1 = NW + 1;
  localparam int unsigned DW  = 2 * W;
  localparam int unsigned DW1 = 2 * W + 1;
  localparam int unsigned W1  = W + 1;
  localparam logic [NW-1:0] POS_MAX = NW'((64'd1 << (W - 1)) - 64'd1);
  localparam logic [NW-1:0] NEG_MAX = NW'(64'd1 << (W - 1));

  state_t r_state, w_state_nxt;

  logic signed [W-1:0] r_a, r_b, r_c, r_d;
  logic signed [W-1:0] r_res [4];
  logic [1:0]          r_idx;
  logic                r_res_neg;
  logic                r_singular;
  logic                r_ovf;
  logic                r_out_valid;
  logic                r_in_ready;

  logic                w_accept;
  logic                w_div_start;
  logic [1:0]          w_start_idx;
  logic signed [DW:0]  w_det;
  logic                w_det_zero;
  logic [DW-1:0]       w_det_mag;
  logic signed [W:0]   w_adj;
  logic [W-1:0]        w_adj_mag;
  logic                w_div_busy;
  logic                w_div_done;
  logic                w_div_last;
  logic [NW-1:0]       w_quot;
  logic [NW-1:0]       w_q_round;
  logic signed [W-1:0] w_elem;
  logic                w_sat;

  // Exact determinant; both products fit comfortably in 2W+1 bits.
  always_comb begin
    w_det      = DW1'(r_a) * DW1'(r_d) - DW1'(r_b) * DW1'(r_c);
    w_det_zero = (w_det == '0);
    w_det_mag  = w_det[DW] ? DW'(-w_det) : DW'(w_det);
  end

  // Adjugate element feeding the next division: d, -b, -c, a.
  always_comb begin
    w_start_idx = (r_state == S_DET) ? 2'd0 : 2'(r_idx + 2'd1);
    case (w_start_idx)
      2'd0:    w_adj = W1'(r_d);
      2'd1:    w_adj = -W1'(r_b);
      2'd2:    w_adj = -W1'(r_c);
      default: w_adj = W1'(r_a);
    endcase
    w_adj_mag = w_adj[W] ? W'(-w_adj) : W'(w_adj);
  end

  udiv_iter #(.NW(NW), .DW(DW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_div_start),
    .i_num    ({w_adj_mag, {(2 * F + 1){1'b0}}}),
    .i_den    (w_det_mag),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_last_c (w_div_last),
    .o_quot   (w_quot)
  );

  // Round half away from zero on the magnitude, then sign and saturate.
  always_comb begin
    w_q_round = NW'(({1'b0, w_quot} + NW1'(1)) >> 1);
    w_sat     = 1'b0;
    if (!r_res_neg) begin
      if (w_q_round > POS_MAX) begin
        w_elem = {1'b0, {(W - 1){1'b1}}};
        w_sat  = 1'b1;
      end else begin
        w_elem = W'(w_q_round);
      end
    end else begin
      if (w_q_round > NEG_MAX) begin
        w_elem = {1'b1, {(W - 1){1'b0}}};
        w_sat  = 1'b1;
      end else begin
        w_elem = W'(-w_q_round);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DET;
        end
      end
      S_DET: begin
        if (w_det_zero) begin
          w_state_nxt = S_DONE;
        end else begin
          w_div_start = 1'b1;
          w_state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (w_div_last || !w_div_busy) w_state_nxt = S_STORE;
      end
      S_STORE: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DONE;
        end else begin
          w_div_start = 1'b1;
          w_state_nxt = S_DIV;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_res       <= '{default: '0};
      r_idx       <= '0;
      r_res_neg   <= 1'b0;
      r_singular  <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      r_in_ready  <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_a        <= a;
        r_b        <= b;
        r_c        <= c;
        r_d        <= d;
        r_res      <= '{default: '0};
        r_idx      <= '0;
        r_singular <= 1'b0;
        r_ovf      <= 1'b0;
      end
      if (w_div_start) r_res_neg <= w_adj[W] ^ w_det[DW];
      if (r_state == S_DET && w_det_zero) r_singular <= 1'b1;
      if (r_state == S_STORE && w_div_done) begin
        r_res[r_idx] <= w_elem;
        r_ovf        <= r_ovf | w_sat;
        r_idx        <= 2'(r_idx + 2'd1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign a_inv     = r_res[0];
  assign b_inv     = r_res[1];
  assign c_inv     = r_res[2];
  assign d_inv     = r_res[3];
  assign singular  = r_singular;
  assign overflow  = r_ovf;

endmodule

// File: doc/mat2_inv_iter.md
MAT2_INV_ITER -- requirements
Module: mat2_inv_iter

Interface
REQ-001 SHALL have parameter W, default 16: element width, two's complement, W >= 4.
REQ-002 SHALL have parameter F, default 14: fractional bits of every element, 0 < F < W.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: input matrix present.
REQ-006 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-007 SHALL have ports a, b, c, d, input, W each, signed: input matrix [a b; c d], Q(W-F).F.
REQ-008 SHALL have port out_valid, output, 1: result present.
REQ-009 SHALL have port out_ready, input, 1: downstream takes the result.
REQ-010 SHALL have ports a_inv, b_inv, c_inv, d_inv, output, W each, signed: inverse, Q(W-F).F.
REQ-011 SHALL have port singular, output, 1: det == 0 for the current result.
REQ-012 SHALL have port overflow, output, 1: at least one element of the current result saturated.

Function
REQ-013 SHALL accept a transaction on a rising edge where in_valid && in_ready, capturing a, b, c, d.
REQ-014 SHALL drive in_ready = 1 only in state IDLE; there is no same-cycle bypass from DONE to accept.
REQ-015 SHALL use states IDLE -> DET -> (DIV -> STORE) x4 -> DONE -> IDLE.
REQ-016 SHALL, in DET (1 cycle), compute det = a*d - b*c exactly at 2W+1 bits, Q(2W-2F+1).2F.
REQ-017 SHALL go DET -> DONE when det == 0, with all four outputs 0 and singular = 1, so out_valid rises 1 cycle after accept.
REQ-018 SHALL otherwise process the adjugate elements in order a_inv = d, b_inv = -b, c_inv = -c, d_inv = a, negating at W+1 bits.
REQ-019 SHALL compute each element as the exact quotient adj * 2^(2F) / det, without a rounded reciprocal step.
REQ-020 SHALL compute each quotient from magnitudes via unsigned restoring division, one quotient bit per cycle, DIV_CYC = W + 2F + 1 cycles per element.
REQ-021 SHALL round the magnitude to nearest with ties away from zero (extra quotient LSB), then apply sign = sign(adj) XOR sign(det).
REQ-022 SHALL saturate each signed result to [-2^(W-1), 2^(W-1)-1] and set overflow if any element saturated.
REQ-023 SHALL register each element in STORE (1 cycle); non-singular latency from the accept edge to out_valid is 1 + 4*(DIV_CYC+1) cycles (185 at defaults).
REQ-024 SHALL hold out_valid and all result outputs stable in DONE until out_ready; the handshake edge returns to IDLE.
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-026 SHALL treat an adj element of 0 as exact 0, with no overflow and no sign artefact.

Reset
REQ-027 SHALL, on a reset edge in any state including mid-division, go to IDLE and abort the transaction.
REQ-028 SHALL clear out_valid, singular, overflow and all result outputs to 0 on reset; in_ready = 1 the cycle after reset deasserts.

Structure
REQ-029 SHALL take the state enum and localparam function div_cycles(W,F) from shared package mat_inv_pkg.
REQ-030 SHALL place the iterative unsigned divider in a sub-module udiv_iter (start/busy/done, numerator W+2F+1 bits, divisor 2W bits), instantiated once and reused for all four elements.

Verification (defaults W=16, F=14; 1.0 = 16384)
REQ-031 SHALL test identity: a=d=16384, b=c=0 -> 16384, 0, 0, 16384; flags 0; out_valid exactly 185 cycles after accept.
REQ-032 SHALL test triangular input: a=16384, b=8192, c=0, d=16384 -> 16384, -8192, 0, 16384.
REQ-033 SHALL test negative det: a=0, b=16384, c=16384, d=0 (det=-1) -> 0, 16384, 16384, 0; overflow 0.
REQ-034 SHALL test overflow: a=d=8192, b=c=0 (inverse 2.0) -> a_inv=d_inv=32767, b_inv=c_inv=0, overflow=1.
REQ-035 SHALL test singular input: a=b=c=d=8192 -> singular=1, outputs 0, out_valid 1 cycle after accept.
REQ-036 SHALL test backpressure and abort: out_ready low 10 cycles -> outputs stable, in_ready 0; reset at cycle 50 of a division -> IDLE, outputs 0, next transaction correct.
